// File: rtl/alu_pkg.sv
// Shared opcode and FSM-state definitions for the alu_seq block.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIV   = 4'd12,
    OP_DIVU  = 4'd13,
    OP_REM   = 4'd14,
    OP_REMU  = 4'd15
  } alu_op_t;

  typedef logic [1:0] alu_state_t;
  localparam alu_state_t S_IDLE = 2'd0;
  localparam alu_state_t S_BUSY = 2'd1;
  localparam alu_state_t S_DONE = 2'd2;

  function automatic logic is_muldiv(input alu_op_t op);
    return op >= OP_MUL;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between issue, alu_seq and writeback.
interface alu_seq_if #(
  parameter int WORDSIZE = 64
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [WORDSIZE-1:0] input_a;
  logic [WORDSIZE-1:0] input_b;
  logic [3:0]          operation;
  logic                out_valid;
  logic                out_ready;
  logic [WORDSIZE-1:0] result;
  logic                overflow;
  logic                illegal;

  modport master (
    output flush, in_valid, input_a, input_b, operation, out_ready,
    input  in_ready, out_valid, result, overflow, illegal
  );

  modport slave (
    input  flush, in_valid, input_a, input_b, operation, out_ready,
    output in_ready, out_valid, result, overflow, illegal
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider on one 2*WORDSIZE accumulator.
// acc carries {hi, lo}: product {hi,lo} for multiply, {remainder, quotient} for divide.
module alu_muldiv_iter #(
  parameter int WORDSIZE  = 64,
  parameter int ITER_BITS = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  is_div,
  input  logic [WORDSIZE-1:0]   op_a,
  input  logic [WORDSIZE-1:0]   op_b,
  output logic                  done,
  output logic [2*WORDSIZE-1:0] acc
);
  localparam int STEPS = WORDSIZE / ITER_BITS;
  localparam int CW    = $clog2(STEPS + 1);

  logic [CW-1:0]         cnt;
  logic                  div_q;
  logic [WORDSIZE-1:0]   opb_q;
  logic [2*WORDSIZE-1:0] acc_q, acc_nx;
  logic [WORDSIZE:0]     part;

  always_comb begin
    acc_nx = acc_q;
    part   = '0;
    for (int j = 0; j < ITER_BITS; j++) begin
      if (div_q) begin
        // trial subtract of the divisor from the shifted partial remainder
        part = acc_nx[2*WORDSIZE-1:WORDSIZE-1] - {1'b0, opb_q};
        if (part[WORDSIZE]) acc_nx = {acc_nx[2*WORDSIZE-2:0], 1'b0};
        else                acc_nx = {part[WORDSIZE-1:0], acc_nx[WORDSIZE-2:0], 1'b1};
      end else begin
        part   = {1'b0, acc_nx[2*WORDSIZE-1:WORDSIZE]} + ({(WORDSIZE+1){acc_nx[0]}} & {1'b0, opb_q});
        acc_nx = {part, acc_nx[WORDSIZE-1:1]};
      end
    end
  end

  // done marks the cycle whose edge completes the final step; acc is that step's value
  assign done = (cnt == CW'(1));
  assign acc  = acc_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      div_q <= 1'b0;
      opb_q <= '0;
      acc_q <= '0;
    end else if (start) begin
      cnt   <= CW'(STEPS);
      div_q <= is_div;
      opb_q <= op_b;
      acc_q <= {{WORDSIZE{1'b0}}, op_a};
    end else if (cnt != '0) begin
      cnt   <= cnt - CW'(1);
      acc_q <= acc_nx;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked RV64 execute ALU, single-cycle datapath plus iterative mul/div.
// Define ALU_MULDIV_EN to build the iterative unit; without it opcodes 10-15 return illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WORDSIZE  = 64,
  parameter int ITER_BITS = 1
) (
  input  logic     clk,
  input  logic     reset_n,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WORDSIZE);

  alu_state_t          state;
  alu_op_t             op;
  logic [WORDSIZE-1:0] a, b, sum, diff, sc_res, md_res, result_q;
  logic [SHW-1:0]      shamt;
  logic                sc_ovf, sc_ill, go_iter, md_done, accept;
  logic                overflow_q, illegal_q;

  assign a      = bus.input_a;
  assign b      = bus.input_b;
  assign op     = alu_op_t'(bus.operation);
  assign shamt  = b[SHW-1:0];
  assign sum    = a + b;
  assign diff   = a - b;
  assign accept = bus.in_valid && (state == S_IDLE) && !bus.flush;

  assign bus.in_ready  = reset_n && (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.illegal   = illegal_q;

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (a[WORDSIZE-1] == b[WORDSIZE-1]) && (sum[WORDSIZE-1] != a[WORDSIZE-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (a[WORDSIZE-1] != b[WORDSIZE-1]) && (diff[WORDSIZE-1] != a[WORDSIZE-1]);
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_SLL:  sc_res = a << shamt;
      OP_SRL:  sc_res = a >> shamt;
      OP_SRA:  sc_res = $signed(a) >>> shamt;
      OP_SLT:  sc_res = {{(WORDSIZE-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: sc_res = {{(WORDSIZE-1){1'b0}}, a < b};
      default: sc_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic [2*WORDSIZE-1:0] md_acc;
  logic [WORDSIZE-1:0]   md_a, md_b, quo, rem;
  logic                  sdiv, md_start, qneg_q, rneg_q;
  alu_op_t               op_q;

  // signed divide runs on magnitudes; signs are restored when entering DONE
  assign sdiv     = (op == OP_DIV) || (op == OP_REM);
  assign md_a     = (sdiv && a[WORDSIZE-1]) ? -a : a;
  assign md_b     = (sdiv && b[WORDSIZE-1]) ? -b : b;
  assign go_iter  = is_muldiv(op);
  assign sc_ill   = 1'b0;
  assign md_start = accept && go_iter;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= OP_ADD;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (md_start) begin
      op_q   <= op;
      // x/0 keeps the all-ones quotient regardless of the dividend sign
      qneg_q <= (op == OP_DIV) && (a[WORDSIZE-1] ^ b[WORDSIZE-1]) && (b != '0);
      rneg_q <= (op == OP_REM) && a[WORDSIZE-1];
    end
  end

  alu_muldiv_iter #(
    .WORDSIZE (WORDSIZE),
    .ITER_BITS(ITER_BITS)
  ) u_md (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (md_start),
    .is_div (bus.operation[2]),
    .op_a   (md_a),
    .op_b   (md_b),
    .done   (md_done),
    .acc    (md_acc)
  );

  assign quo = md_acc[WORDSIZE-1:0];
  assign rem = md_acc[2*WORDSIZE-1:WORDSIZE];

  always_comb begin
    md_res = '0;
    case (op_q)
      OP_MUL:          md_res = quo;
      OP_MULHU:        md_res = rem;
      OP_DIV, OP_DIVU: md_res = qneg_q ? -quo : quo;
      default:         md_res = rneg_q ? -rem : rem;
    endcase
  end
`else
  assign go_iter = 1'b0;
  assign md_done = 1'b0;
  assign md_res  = '0;
  assign sc_ill  = is_muldiv(op);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      result_q   <= '0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (bus.flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          if (go_iter) begin
            state <= S_BUSY;
          end else begin
            state      <= S_DONE;
            result_q   <= sc_res;
            overflow_q <= sc_ovf;
            illegal_q  <= sc_ill;
          end
        end
        S_BUSY: if (md_done) begin
          state      <= S_DONE;
          result_q   <= md_res;
          overflow_q <= 1'b0;
          illegal_q  <= 1'b0;
        end
        S_DONE:  if (bus.out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed + scoreboard bench for alu_seq (WORDSIZE=64, ITER_BITS=1); follows ALU_MULDIV_EN.
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct packed {
    logic [63:0] res;
    logic        ovf;
    logic        ill;
  } exp_t;

  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef ALU_MULDIV_EN
  localparam int MDLAT = 65;
`else
  localparam int MDLAT = 1;
`endif

  logic clk, reset_n;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  alu_seq_if #(.WORDSIZE(64)) bus ();

  alu_seq #(.WORDSIZE(64), .ITER_BITS(1)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] res, input logic ovf, input logic ill);
    exp_t e;
    e.res = res;
    e.ovf = ovf;
    e.ill = ill;
    return e;
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic signed [64:0] s;
    logic [127:0] p;
    e = '0;
    s = '0;
    p = '0;
    case (op)
      4'd0: begin s = $signed({a[63], a}) + $signed({b[63], b}); e.res = s[63:0]; e.ovf = s[64] ^ s[63]; end
      4'd1: begin s = $signed({a[63], a}) - $signed({b[63], b}); e.res = s[63:0]; e.ovf = s[64] ^ s[63]; end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = a << b[5:0];
      4'd6: e.res = a >> b[5:0];
      4'd7: e.res = $signed(a) >>> b[5:0];
      4'd8: e.res = {63'd0, $signed(a) < $signed(b)};
      4'd9: e.res = {63'd0, a < b};
`ifdef ALU_MULDIV_EN
      4'd10: e.res = a * b;
      4'd11: begin p = {64'd0, a} * {64'd0, b}; e.res = p[127:64]; end
      4'd12: e.res = (b == 0) ? ONES : (a == MIN && b == ONES) ? MIN : $signed(a) / $signed(b);
      4'd13: e.res = (b == 0) ? ONES : a / b;
      4'd14: e.res = (b == 0) ? a : (a == MIN && b == ONES) ? 64'd0 : $signed(a) % $signed(b);
      4'd15: e.res = (b == 0) ? a : a % b;
`endif
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input exp_t e, input int lat);
    exp_t got;
    int   n;
    sb.push_back(e);
    @(negedge clk);
    chk("in_ready_idle", {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid  = 1'b1;
    bus.operation = op;
    bus.input_a   = a;
    bus.input_b   = b;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.operation = 'x;
    bus.input_a   = 'x;
    bus.input_b   = 'x;
    n = 1;
    if (lat > 1) chk("in_ready_busy", {63'd0, bus.in_ready}, 64'd0);
    while (bus.out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    got = sb.pop_front();
    chk("result", bus.result, got.res);
    chk("overflow", {63'd0, bus.overflow}, {63'd0, got.ovf});
    chk("illegal", {63'd0, bus.illegal}, {63'd0, got.ill});
    @(posedge clk); #1;
    chk("out_valid_drop", {63'd0, bus.out_valid}, 64'd0);
  endtask

  initial begin
    exp_t        e0;
    logic [3:0]  rop;
    logic [63:0] ra, rb;
    logic        seen;

    reset_n       = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.operation = '0;
    bus.input_a   = '0;
    bus.input_b   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_overflow", {63'd0, bus.overflow}, 64'd0);
    chk("rst_illegal", {63'd0, bus.illegal}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("in_ready_after_rst", {63'd0, bus.in_ready}, 64'd1);

    run_op(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, mk(MIN, 1'b1, 1'b0), 1);
    run_op(OP_SUB, MIN, 64'd1, mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0), 1);
    run_op(OP_SUB, 64'd5, 64'd7, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0), 1);
    run_op(OP_SRA, MIN, 64'h41, mk(64'hC000_0000_0000_0000, 1'b0, 1'b0), 1);
    run_op(OP_SRL, MIN, 64'h41, mk(64'h4000_0000_0000_0000, 1'b0, 1'b0), 1);
    run_op(OP_SLL, 64'd1, 64'd63, mk(MIN, 1'b0, 1'b0), 1);
    run_op(OP_SLTU, 64'd1, ONES, mk(64'd1, 1'b0, 1'b0), 1);
    run_op(OP_SLT, 64'd1, ONES, mk(64'd0, 1'b0, 1'b0), 1);
    run_op(OP_AND, 64'hF0F0, 64'hFF00, mk(64'hF000, 1'b0, 1'b0), 1);
    run_op(OP_XOR, 64'hF0F0, 64'hFF00, mk(64'h0FF0, 1'b0, 1'b0), 1);

`ifdef ALU_MULDIV_EN
    run_op(OP_MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF, mk(64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0), 65);
    run_op(OP_MULHU, ONES, ONES, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0), 65);
    run_op(OP_DIV, 64'd7, 64'd0, mk(ONES, 1'b0, 1'b0), 65);
    run_op(OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, mk(64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0), 65);
    run_op(OP_DIV, MIN, ONES, mk(MIN, 1'b0, 1'b0), 65);
    run_op(OP_REM, MIN, ONES, mk(64'd0, 1'b0, 1'b0), 65);
    run_op(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, mk(64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0), 65);
    run_op(OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, mk(ONES, 1'b0, 1'b0), 65);
    run_op(OP_DIVU, 64'd9, 64'd3, mk(64'd3, 1'b0, 1'b0), 65);
`else
    run_op(OP_DIVU, 64'd9, 64'd3, mk(64'd0, 1'b0, 1'b1), 1);
    run_op(OP_MUL, 64'd3, 64'd4, mk(64'd0, 1'b0, 1'b1), 1);
`endif

    for (int i = 0; i < 10; i++) begin
      rop = 4'($urandom_range(0, 9));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      run_op(rop, ra, rb, model(rop, ra, rb), 1);
    end
    for (int i = 0; i < 4; i++) begin
      rop = 4'($urandom_range(10, 15));
      ra  = {$urandom, $urandom};
      rb  = {32'd0, $urandom};
      run_op(rop, ra, rb, model(rop, ra, rb), MDLAT);
    end

    // consumer stalls: result must hold and no new op may be taken
    sb.push_back(mk(64'hFF, 1'b0, 1'b0));
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.operation = OP_OR;
    bus.input_a   = 64'hF0;
    bus.input_b   = 64'h0F;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    e0 = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("bp_result", bus.result, e0.res);
      chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {63'd0, bus.out_valid}, 64'd0);

    // flush beats a simultaneous accept
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.flush     = 1'b1;
    bus.operation = OP_ADD;
    bus.input_a   = 64'd1;
    bus.input_b   = 64'd1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    chk("flush_acc_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flush_acc_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1;
    chk("flush_acc_late", {63'd0, bus.out_valid}, 64'd0);

    // flush while a result is held
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.operation = OP_XOR;
    bus.input_a   = 64'd3;
    bus.input_b   = 64'd5;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("flushd_pre", {63'd0, bus.out_valid}, 64'd1);
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flushd_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flushd_ready", {63'd0, bus.in_ready}, 64'd1);

`ifdef ALU_MULDIV_EN
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.operation = OP_MUL;
    bus.input_a   = 64'd3;
    bus.input_b   = 64'd5;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flushb_ready", {63'd0, bus.in_ready}, 64'd1);
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    chk("flushb_no_valid", {63'd0, seen}, 64'd0);

    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.operation = OP_DIVU;
    bus.input_a   = ONES;
    bus.input_b   = 64'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
`else
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.operation = OP_ADD;
    bus.input_a   = 64'h7FFF_FFFF_FFFF_FFFF;
    bus.input_b   = 64'd1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("arst_pre_valid", {63'd0, bus.out_valid}, 64'd1);
`endif
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("arst_result", bus.result, 64'd0);
    chk("arst_overflow", {63'd0, bus.overflow}, 64'd0);
    chk("arst_illegal", {63'd0, bus.illegal}, 64'd0);
    chk("arst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    @(negedge clk);
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    run_op(OP_ADD, 64'd2, 64'd3, mk(64'd5, 1'b0, 1'b0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
